wb_cmd_master: RTL

// Hardware Wishbone classic initiator: the bus-master side of the register interface used by pwm_timer.

---
 rtl/wb_cmd_master_if.sv | 45 ++++
 rtl/wb_cmd_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - command stream, response stream and Wishbone bus bundle for wb_cmd_master
interface wb_cmd_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Command stream
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_we;
    logic [ADDR_W-1:0] i_cmd_adr;
    logic [DATA_W-1:0] i_cmd_data;

    // Response stream
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_data;
    logic              o_rsp_err;

    // Wishbone classic bus
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              o_wb_we;
    logic [ADDR_W-1:0] o_wb_adr;
    logic [DATA_W-1:0] o_wb_data;
    logic              i_wb_ack;
    logic [DATA_W-1:0] i_wb_data;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_data,
        input  i_rsp_ready,
        input  i_wb_ack, i_wb_data,
        output o_cmd_ready,
        output o_rsp_valid, o_rsp_data, o_rsp_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_data,
        output i_rsp_ready,
        output i_wb_ack, i_wb_data,
        input  o_cmd_ready,
        input  o_rsp_valid, o_rsp_data, o_rsp_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data
    );
endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - FIFO-buffered Wishbone classic initiator with timeout and per-command response
module wb_cmd_master #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    wb_cmd_master_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Command FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [CMD_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [CMD_W-1:0] head;
    logic             head_we;
    logic [ADDR_W-1:0] head_adr;
    logic [DATA_W-1:0] head_data;

    // Sequencer state and registered outputs
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Ready depends only on registered pointers, so a pop in the same cycle never opens a slot
    assign bus.o_cmd_ready = !fifo_full;
    assign push            = bus.i_cmd_valid && !fifo_full;

    assign head = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign {head_we, head_adr, head_data} = head;

    // FIFO payload write; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.i_cmd_we, bus.i_cmd_adr, bus.i_cmd_data};
        end
    end

    // Next-state logic: pop in IDLE, run the bus cycle with timeout in BUS, hold the response in RESP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cyc_d   = 1'b1;
                    we_d    = head_we;
                    adr_d   = head_adr;
                    wdata_d = head_data;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // Ack is tested first so an ack on the timeout edge still completes normally
                if (bus.i_wb_ack) begin
                    cyc_d       = 1'b0;
                    rsp_data_d  = we_q ? '0 : bus.i_wb_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cyc_d       = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
    end

    // State and output registers; reset flushes the FIFO and abandons any in-flight cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    assign bus.o_wb_cyc    = cyc_q;
    assign bus.o_wb_stb    = cyc_q;
    assign bus.o_wb_we     = we_q;
    assign bus.o_wb_adr    = adr_q;
    assign bus.o_wb_data   = wdata_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_err   = rsp_err_q;
endmodule
